// File: rtl/imm_pkg.sv
// Shared definitions for the sequential immediate extender.
//   - imm_src mode encodings
//   - FSM state type
//   - rotate counter width and a 32-bit rotate-right helper
package imm_pkg;

    localparam int unsigned ROT_CNT_W = 5;

    localparam logic [2:0] IMM_8    = 3'b000;
    localparam logic [2:0] IMM_12   = 3'b001;
    localparam logic [2:0] IMM_BR   = 3'b010;
    localparam logic [2:0] IMM_MOVW = 3'b011;
    localparam logic [2:0] IMM_MOVT = 3'b100;
    localparam logic [2:0] IMM_MOVM = 3'b101;
    localparam logic [2:0] IMM_ROT  = 3'b110;
    localparam logic [2:0] IMM_RSVD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    // Rotate right by amt (0..31); doubling the word makes the wrap free.
    function automatic logic [31:0] ror32(logic [31:0] val, logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {val, val} >> amt;
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/imm_extend_seq_if.sv
// Request/result bus of the immediate extender.
//   in_valid/in_ready : request handshake
//   instr, imm_src    : instruction field and mode
//   carry_in          : current CPSR.C
//   out_valid/out_ready : result handshake
//   ext_imm, carry_out  : result
// master = instruction-side requester, slave = the extender.
interface imm_extend_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [23:0] instr;
    logic [2:0]  imm_src;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext_imm;
    logic        carry_out;

    modport master (
        output in_valid, instr, imm_src, carry_in, out_ready,
        input  in_ready, out_valid, ext_imm, carry_out
    );

    modport slave (
        input  in_valid, instr, imm_src, carry_in, out_ready,
        output in_ready, out_valid, ext_imm, carry_out
    );

endinterface

// File: rtl/imm_decode_comb.sv
// Combinational mode decode for the immediate extender.
//   instr, imm_src, carry_in : request fields
//   result, carry            : final value for single-cycle modes
//   rot_start                : ROT mode with a non-zero rotate field
//   work_init, rem_init      : rotator seed (imm8) and rotate amount in bits
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int unsigned BR_SHIFT = 2,
    parameter int unsigned EN_MOVM  = 1
) (
    input  logic [23:0]          instr,
    input  logic [2:0]           imm_src,
    input  logic                 carry_in,
    output logic [31:0]          result,
    output logic                 carry,
    output logic                 rot_start,
    output logic [31:0]          work_init,
    output logic [ROT_CNT_W-1:0] rem_init
);

    logic [31:0] br_sext;

    always_comb begin
        br_sext   = {{8{instr[23]}}, instr};
        result    = 32'd0;
        carry     = carry_in;
        work_init = {24'd0, instr[7:0]};
        rem_init  = {instr[11:8], 1'b0};
        rot_start = (imm_src == IMM_ROT) && (instr[11:8] != 4'd0);

        unique case (imm_src)
            IMM_8:    result = {24'd0, instr[7:0]};
            IMM_12:   result = {20'd0, instr[11:0]};
            IMM_BR:   result = br_sext << BR_SHIFT;
            IMM_MOVW: result = {16'd0, instr[19:16], instr[11:0]};
            IMM_MOVT: result = {instr[19:16], instr[11:0], 16'd0};
            IMM_MOVM: result = (EN_MOVM != 0) ? {12'd0, instr[7:0], 12'd0} : 32'd0;
            // Zero rotate: plain imm8 with carry passed through. Non-zero
            // rotates take the iterative path and ignore this value.
            IMM_ROT:  result = {24'd0, instr[7:0]};
            IMM_RSVD: result = 32'd0;
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/imm_extend_seq.sv
// Sequential immediate extender with an iterative rotator for the ARM
// rotated imm8 form.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous abort; returns to IDLE, keeps ext_imm
//   busy         : high while rotating
//   bus          : request/result handshake (slave side)
module imm_extend_seq
    import imm_pkg::*;
#(
    parameter int unsigned ROT_STEP = 2,
    parameter int unsigned BR_SHIFT = 2,
    parameter int unsigned EN_MOVM  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    output logic              busy,
    imm_extend_seq_if.slave   bus
);

    localparam logic [5:0] STEP = 6'(ROT_STEP);

    state_e                 state_q, state_d;
    logic [31:0]            work_q;
    logic [ROT_CNT_W-1:0]   rem_q;
    logic [31:0]            ext_imm_q;
    logic                   carry_q;

    logic [31:0]            dec_result;
    logic                   dec_carry;
    logic                   dec_rot;
    logic [31:0]            dec_work;
    logic [ROT_CNT_W-1:0]   dec_rem;

    logic                   accept;
    logic [5:0]             step;
    logic [31:0]            work_rot;
    logic [ROT_CNT_W-1:0]   rem_next;
    logic                   rot_done;

    imm_decode_comb #(
        .BR_SHIFT (BR_SHIFT),
        .EN_MOVM  (EN_MOVM)
    ) u_decode (
        .instr     (bus.instr),
        .imm_src   (bus.imm_src),
        .carry_in  (bus.carry_in),
        .result    (dec_result),
        .carry     (dec_carry),
        .rot_start (dec_rot),
        .work_init (dec_work),
        .rem_init  (dec_rem)
    );

    // Rotator step: clamp to the remaining amount so rem never underflows.
    always_comb begin
        step     = ({1'b0, rem_q} < STEP) ? {1'b0, rem_q} : STEP;
        work_rot = ror32(work_q, step[4:0]);
        rem_next = rem_q - step[4:0];
        rot_done = (rem_next == '0);
        accept   = bus.in_valid && (state_q == S_IDLE) && !flush;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (bus.in_valid) state_d = dec_rot ? S_ROTATE : S_HOLD;
                S_ROTATE: if (rot_done) state_d = S_HOLD;
                S_HOLD:   if (bus.out_ready) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_HOLD);
        busy          = (state_q == S_ROTATE);
        bus.ext_imm   = ext_imm_q;
        bus.carry_out = carry_q;
    end

    // Datapath: result registers load only on the edge that enters HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_q    <= 32'd0;
            rem_q     <= '0;
            ext_imm_q <= 32'd0;
            carry_q   <= 1'b0;
        end else if (flush) begin
            rem_q <= '0;
        end else if (accept) begin
            if (dec_rot) begin
                work_q <= dec_work;
                rem_q  <= dec_rem;
            end else begin
                ext_imm_q <= dec_result;
                carry_q   <= dec_carry;
            end
        end else if (state_q == S_ROTATE) begin
            work_q <= work_rot;
            rem_q  <= rem_next;
            if (rot_done) begin
                ext_imm_q <= work_rot;
                carry_q   <= work_rot[31];
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_seq.sv
module tb_imm_extend_seq;
    import imm_pkg::*;

    logic clk;
    logic reset_n;
    logic flush;
    logic busy_a, busy_b;
    bit   sel;  // 0: dut_a (ROT_STEP 2), 1: dut_b (ROT_STEP 32)

    int n_vec = 0;
    int n_err = 0;

    imm_extend_seq_if bus_a ();
    imm_extend_seq_if bus_b ();

    imm_extend_seq #(.ROT_STEP(2), .BR_SHIFT(2), .EN_MOVM(1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .busy    (busy_a),
        .bus     (bus_a)
    );

    imm_extend_seq #(.ROT_STEP(32), .BR_SHIFT(2), .EN_MOVM(1)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .busy    (busy_b),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        ov, ir, co, bz;
    logic [31:0] ext;
    always_comb begin
        ov  = sel ? bus_b.out_valid : bus_a.out_valid;
        ir  = sel ? bus_b.in_ready  : bus_a.in_ready;
        co  = sel ? bus_b.carry_out : bus_a.carry_out;
        bz  = sel ? busy_b          : busy_a;
        ext = sel ? bus_b.ext_imm   : bus_a.ext_imm;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit v, input logic [2:0] mode, input logic [23:0] ins,
                           input bit cin);
        bus_a.in_valid = v && !sel;
        bus_b.in_valid = v && sel;
        bus_a.imm_src  = mode;
        bus_b.imm_src  = mode;
        bus_a.instr    = ins;
        bus_b.instr    = ins;
        bus_a.carry_in = cin;
        bus_b.carry_in = cin;
    endtask

    task automatic set_ready(input bit r);
        bus_a.out_ready = r;
        bus_b.out_ready = r;
    endtask

    // One request, then check latency, busy cycles, result and release.
    task automatic run_vec(input string tag, input bit s, input logic [2:0] mode,
                           input logic [23:0] ins, input bit cin, input logic [31:0] eimm,
                           input bit eco, input int elat, input int ebusy);
        int lat;
        int nb;
        sel = s;
        set_ready(1'b0);
        @(negedge clk);
        set_req(1'b1, mode, ins, cin);
        @(negedge clk);
        set_req(1'b0, IMM_RSVD, ~ins, ~cin);  // inputs need not be held
        lat = 1;
        nb  = 0;
        while (!ov && lat < 40) begin
            if (bz) nb++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_valid"}, ov, 1'b1);
        chk({tag, "_busy"}, nb, ebusy);
        chk({tag, "_imm"}, ext, eimm);
        chk({tag, "_co"}, co, eco);
        chk({tag, "_rdy_hold"}, ir, 1'b0);
        set_ready(1'b1);
        @(negedge clk);
        set_ready(1'b0);
        chk({tag, "_rdy_after"}, ir, 1'b1);
        chk({tag, "_valid_after"}, ov, 1'b0);
        chk({tag, "_imm_kept"}, ext, eimm);
    endtask

    initial begin
        int n_ov;
        sel     = 1'b0;
        reset_n = 1'b0;
        flush   = 1'b0;
        set_req(1'b0, IMM_8, 24'd0, 1'b0);
        set_ready(1'b0);
        repeat (3) @(negedge clk);

        chk("rst_ready", ir, 1'b1);
        chk("rst_valid", ov, 1'b0);
        chk("rst_busy", bz, 1'b0);
        chk("rst_imm", ext, 32'd0);
        chk("rst_co", co, 1'b0);
        chk("rst_b_ready", bus_b.in_ready, 1'b1);
        reset_n = 1'b1;

        //      tag      dut  mode      instr         cin  ext_imm        co   lat busy
        run_vec("m8",    0, IMM_8,    24'h0000A5, 0, 32'h000000A5, 0, 1, 0);
        run_vec("m12",   0, IMM_12,   24'h123ABC, 1, 32'h00000ABC, 1, 1, 0);
        run_vec("br_n",  0, IMM_BR,   24'hFFFFFE, 0, 32'hFFFFFFF8, 0, 1, 0);
        run_vec("br_p",  0, IMM_BR,   24'h000003, 1, 32'h0000000C, 1, 1, 0);
        run_vec("movw",  0, IMM_MOVW, 24'h0A0BCD, 0, 32'h0000ABCD, 0, 1, 0);
        run_vec("movt",  0, IMM_MOVT, 24'h0A0BCD, 0, 32'hABCD0000, 0, 1, 0);
        run_vec("movm",  0, IMM_MOVM, 24'h0000C3, 1, 32'h000C3000, 1, 1, 0);
        run_vec("rsvd",  0, IMM_RSVD, 24'hFFFFFF, 1, 32'h00000000, 1, 1, 0);
        run_vec("rot8",  0, IMM_ROT,  24'h0004FF, 0, 32'hFF000000, 1, 5, 4);
        run_vec("rot0",  0, IMM_ROT,  24'h000080, 1, 32'h00000080, 1, 1, 0);
        run_vec("rot2",  0, IMM_ROT,  24'h000101, 1, 32'h40000000, 0, 2, 1);
        run_vec("b_rot8", 1, IMM_ROT, 24'h0004FF, 0, 32'hFF000000, 1, 2, 1);
        run_vec("b_rot30", 1, IMM_ROT, 24'h000F01, 1, 32'h00000004, 0, 2, 1);
        run_vec("b_m8",  1, IMM_8,    24'h00003C, 1, 32'h0000003C, 1, 1, 0);

        // Backpressure: result held, second request ignored.
        sel = 1'b0;
        @(negedge clk);
        set_req(1'b1, IMM_8, 24'h00005A, 1'b0);
        @(negedge clk);
        set_req(1'b0, IMM_8, 24'd0, 1'b0);
        chk("bp_valid0", ov, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", ov, 1'b1);
            chk("bp_imm", ext, 32'h0000005A);
            chk("bp_ready", ir, 1'b0);
            if (i == 1) set_req(1'b1, IMM_12, 24'h000FFF, 1'b1);
            @(negedge clk);
        end
        set_req(1'b0, IMM_8, 24'd0, 1'b0);
        set_ready(1'b1);
        @(negedge clk);
        set_ready(1'b0);
        chk("bp_ready_after", ir, 1'b1);
        chk("bp_valid_after", ov, 1'b0);
        chk("bp_imm_after", ext, 32'h0000005A);
        chk("bp_co_after", co, 1'b0);
        @(negedge clk);
        chk("bp_no_second", ov, 1'b0);

        // Flush on the second ROTATE cycle.
        @(negedge clk);
        set_req(1'b1, IMM_ROT, 24'h0004FF, 1'b1);
        @(negedge clk);
        set_req(1'b0, IMM_8, 24'd0, 1'b0);
        chk("fl_busy1", bz, 1'b1);
        @(negedge clk);
        chk("fl_busy2", bz, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_busy_off", bz, 1'b0);
        chk("fl_ready", ir, 1'b1);
        chk("fl_valid", ov, 1'b0);
        chk("fl_imm_kept", ext, 32'h0000005A);
        n_ov = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov) n_ov++;
        end
        chk("fl_never_valid", n_ov, 0);

        // Request in the same cycle as flush is dropped.
        set_req(1'b1, IMM_8, 24'h000033, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        set_req(1'b0, IMM_8, 24'd0, 1'b0);
        flush = 1'b0;
        chk("fl_drop_valid", ov, 1'b0);
        chk("fl_drop_busy", bz, 1'b0);
        chk("fl_drop_ready", ir, 1'b1);
        @(negedge clk);
        chk("fl_drop_valid2", ov, 1'b0);
        chk("fl_drop_imm", ext, 32'h0000005A);

        // Asynchronous reset in the middle of a rotate.
        set_req(1'b1, IMM_ROT, 24'h0004FF, 1'b1);
        @(negedge clk);
        set_req(1'b0, IMM_8, 24'd0, 1'b0);
        @(negedge clk);
        chk("ar_busy", bz, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_busy_off", bz, 1'b0);
        chk("ar_ready", ir, 1'b1);
        chk("ar_valid", ov, 1'b0);
        chk("ar_imm", ext, 32'd0);
        chk("ar_co", co, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec("post_rst", 0, IMM_12, 24'h000123, 1, 32'h00000123, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imm_extend_seq.md
Name: imm_extend_seq

Overview:
- Parametrised, sequential successor to the multi-cycle core's immediate extender.
- Accepts a 24-bit instruction field plus a 3-bit immediate mode through a valid/ready handshake.
- Produces the 32-bit extended immediate and the shifter carry-out. Besides the existing formats, it decodes the ARM data-processing rotated imm8, using an iterative rotator so a full barrel shifter is not needed.
- Sits between the instruction register and the ALU source mux; the control FSM waits on out_valid before entering EXECUTE.

Parameters:
- ROT_STEP, 2, bits rotated per cycle in ROTATE state; legal values 1, 2, 4, 8, 16, 32.
- BR_SHIFT, 2, left shift applied to the branch offset; legal values 1 or 2.
- EN_MOVM, 1, 1 = MOVM mode decoded; 0 = MOVM mode treated as reserved.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous abort of any in-flight operation.
- in_valid, input, 1, request valid.
- in_ready, output, 1, block can accept a request.
- instr, input, 24, Instr[23:0] field.
- imm_src, input, 3, mode select.
- carry_in, input, 1, current CPSR.C.
- out_valid, output, 1, ext_imm / carry_out valid.
- out_ready, input, 1, consumer accepts the result.
- ext_imm, output, 32, extended immediate.
- carry_out, output, 1, shifter carry.
- busy, output, 1, high in ROTATE state.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; ext_imm 0; carry_out 0; out_valid 0; busy 0; in_ready 1; rotate counter 0.
- States: IDLE, ROTATE, HOLD.
  - in_ready = (state == IDLE).
  - out_valid = (state == HOLD).
  - busy = (state == ROTATE).
- Accept occurs on in_valid & in_ready. Inputs are captured at accept and need not be held afterwards.
- imm_src decode at accept (all values are 32-bit results):
  - 000: {24'b0, instr[7:0]}.
  - 001: {20'b0, instr[11:0]}.
  - 010: sign-extend instr[23:0], then shift left by BR_SHIFT.
  - 011 MOVW: {16'b0, instr[19:16], instr[11:0]}.
  - 100 MOVT: {instr[19:16], instr[11:0], 16'b0}.
  - 101 MOVM: {12'b0, instr[7:0], 12'b0} when EN_MOVM = 1; otherwise 0.
  - 110 ROT: {24'b0, instr[7:0]} rotated right by 2*instr[11:8].
  - 111 reserved: result 0.
- carry_out:
  - = carry_in for every mode except ROT.
  - For ROT: = result[31] if instr[11:8] != 0; otherwise carry_in.
- Non-ROT modes, and ROT with instr[11:8] == 0: IDLE -> HOLD. Result is registered at accept, so out_valid is high on the cycle after accept (latency 1).
- ROT with instr[11:8] != 0:
  - At accept: IDLE -> ROTATE; load the work register with the zero-extended imm8 and the counter with rem = 2*instr[11:8] (range 2..30, 5 bits).
  - Each ROTATE cycle: rotate the work register right by min(ROT_STEP, rem), then rem -= that amount.
  - When rem reaches 0: -> HOLD, with carry_out = bit 31 of the final value.
  - Latency = 1 + ceil(2*rot / ROT_STEP) cycles from accept to out_valid. With ROT_STEP = 32 this is always 2.
- ext_imm is updated only on the HOLD entry edge; it is stable and held throughout HOLD.
- HOLD -> IDLE when out_ready = 1. ext_imm and carry_out keep their values after leaving HOLD until the next result is loaded.
- No back-to-back accept: the earliest next accept is the cycle after the HOLD->IDLE transition.
- flush (synchronous):
  - Has priority over all transitions: state -> IDLE; out_valid 0 next cycle; ext_imm retained.
  - A request presented in the same cycle as flush is dropped.
- in_valid while not in IDLE is ignored (no accept).
- reset_n asserted mid-ROTATE: immediate return to reset values.
- No arithmetic overflow is possible. The rotate is mod 32, and rem never underflows because of the min() clamp.

Decomposition:
- Package imm_pkg holds:
  - the imm_src encoding constants (IMM_8, IMM_12, IMM_BR, IMM_MOVW, IMM_MOVT, IMM_MOVM, IMM_ROT, IMM_RSVD);
  - the state enum (S_IDLE, S_ROTATE, S_HOLD);
  - localparam ROT_CNT_W = 5.
- One sub-module, imm_decode_comb: the purely combinational mode decode (non-ROT result, initial work value, initial rem). The FSM, rotator and handshake stay in the top module.

Test Plan:
- Mode 000, instr = 0x0000A5 -> one cycle after accept: out_valid = 1, ext_imm = 0x000000A5, carry_out = carry_in.
- Mode 010, instr = 0xFFFFFE, BR_SHIFT = 2 -> ext_imm = 0xFFFFFFF8. Mode 100, instr = 0x0A0BCD -> ext_imm = 0xABCD0000.
- Mode 110, instr = 0x0004FF (rot = 4, amount 8), ROT_STEP = 2 -> busy for 4 cycles, out_valid at cycle 5, ext_imm = 0xFF000000, carry_out = 1. Repeat with ROT_STEP = 32 -> out_valid at cycle 2, same result.
- Mode 110, instr = 0x000080 (rot = 0), carry_in = 1 -> ext_imm = 0x00000080, carry_out = 1, latency 1.
- Backpressure: out_ready held 0 for 5 cycles -> out_valid stays 1, ext_imm stable, in_ready = 0, second in_valid ignored. After out_ready pulses, in_ready = 1 the next cycle.
- flush asserted on the 2nd ROTATE cycle -> IDLE next cycle, out_valid never rises. reset_n pulsed low mid-ROTATE -> all outputs return to reset values immediately.
